// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the multicycle core and its later pipelined variant.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction for all RV32I formats; unknown opcodes yield zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_ir,
  output logic [XLEN-1:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_ir[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        o_imm = {{20{i_ir[31]}}, i_ir[31:20]};
      OP_STORE:
        o_imm = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      OP_BRANCH:
        o_imm = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        o_imm = {i_ir[31:12], 12'b0};
      OP_JAL:
        o_imm = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      default:
        o_imm = '0;
    endcase
  end

endmodule

// File: rtl/pc_ir_mem_unit.sv
// Fetch/memory stage of the multicycle core: PC/OldPC/IR/MDR/ALUOut registers,
// unified word memory with zero-latency read, and instruction field decode.
module pc_ir_mem_unit
  import riscv_pkg::*;
#(
  parameter int              MEM_WORDS = 256,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter string           INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              PCSource,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  input  logic [XLEN-1:0]   reg_b,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   old_pc,
  output logic [6:0]        opcode,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   mdr,
  output logic [XLEN-1:0]   alu_out,
  output logic              mem_fault
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [XLEN-1:0] r_pc, r_old_pc, r_ir, r_mdr, r_alu_out;
  logic            r_mem_fault;
  logic [XLEN-1:0] r_mem [MEM_WORDS];

  logic [XLEN-1:0] w_addr, w_rdata, w_pc_next;
  logic [AW-1:0]   w_idx;
  logic            w_pc_en, w_we, w_conflict, w_misalign, w_pc_misalign, w_fault_set;
  logic            w_unused_addr_bits;

  // Word index drops the byte offset; upper address bits wrap modulo the depth.
  assign w_addr  = IorD ? r_alu_out : r_pc;
  assign w_idx   = w_addr[AW+1:2];
  assign w_rdata = r_mem[w_idx];
  assign w_unused_addr_bits = ^{w_addr[XLEN-1:AW+2], w_addr[1:0]};

  assign w_we          = MemWrite & ~MemRead;
  assign w_conflict    = MemWrite & MemRead;
  assign w_misalign    = (MemRead | MemWrite) & IorD & (r_alu_out[1:0] != 2'b00);
  assign w_pc_en       = PCWrite | (PCWriteCond & alu_zero);
  assign w_pc_next     = PCSource ? r_alu_out : alu_result;
  assign w_pc_misalign = w_pc_en & (w_pc_next[1:0] != 2'b00);
  assign w_fault_set   = w_conflict | w_misalign | w_pc_misalign;

  // Memory contents survive reset; a write at an edge seen while in reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && w_we) begin
      r_mem[w_idx] <= reg_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_old_pc    <= RESET_PC;
      r_ir        <= NOP_INSTR;
      r_mdr       <= '0;
      r_alu_out   <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      r_alu_out <= alu_result;
      if (w_pc_en) begin
        r_pc <= {w_pc_next[XLEN-1:2], 2'b00};
      end
      if (IRWrite) begin
        r_ir     <= w_rdata;
        r_old_pc <= r_pc;
      end else if (MemRead) begin
        r_mdr <= w_rdata;
      end
      if (w_fault_set) begin
        r_mem_fault <= 1'b1;
      end
    end
  end

  imm_gen u_imm_gen (
    .i_ir  (r_ir),
    .o_imm (imm)
  );

  assign pc        = r_pc;
  assign old_pc    = r_old_pc;
  assign opcode    = r_ir[6:0];
  assign rd        = r_ir[11:7];
  assign rs1       = r_ir[19:15];
  assign rs2       = r_ir[24:20];
  assign funct3    = r_ir[14:12];
  assign funct7    = r_ir[31:25];
  assign mdr       = r_mdr;
  assign alu_out   = r_alu_out;
  assign mem_fault = r_mem_fault;

endmodule
